uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: launches queued bytes with a one-cycle
// tx_start pulse, waits for the UART busy handshake and retries unacknowledged launches.
module uart_tx_feeder #(
  parameter int DEPTH     = 16,
  parameter int ACK_LIMIT = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   sent_count
);

  localparam int CW = $clog2(ACK_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, START, ACK, DRAIN} state_t;

  logic [7:0]    mem [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic [15:0]   sent_q, sent_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;
  logic          wr_ok;
  logic          drop;
  logic          full_w;
  logic          empty_w;

  assign full_w  = (level_q == (AW+1)'(DEPTH));
  assign empty_w = (level_q == '0);
  // A full FIFO refuses the write even when a pop frees a slot on the same edge.
  assign wr_ok   = wr_en && !full_w;
  assign drop    = wr_en && full_w;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    sent_d     = sent_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty_w && !tx_busy) begin
          pop        = 1'b1;
          tx_data_d  = mem[rptr_q];
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = ACK;
      end
      ACK: begin
        if (tx_busy) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // No acknowledge in time: relaunch the same byte without popping.
          if (cnt_d == CW'(ACK_LIMIT)) begin
            tx_start_d = 1'b1;
            state_d    = START;
          end
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          sent_d  = sent_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ok) wptr_d = wptr_q + AW'(1);
    if (pop)   rptr_d = rptr_q + AW'(1);

    case ({wr_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      sent_q     <= 16'h0000;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      sent_q     <= sent_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= wr_data;
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign sent_count = sent_q;

endmodule
